// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state codes and length decoding.
package serial_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // A zero or oversized length request means "send the whole register".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_piso_shift.sv
// Parallel-load, MSB-first shift register with zero fill; exposes the MSB it is about to hold.
module piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb_next_c
);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_n;

    // Load has priority over shift.
    always_comb begin
        shreg_n = shreg;
        if (load) begin
            shreg_n = din;
        end else if (shift) begin
            shreg_n = {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign msb_next_c = shreg_n[WIDTH-1];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shreg <= '0;
        end else begin
            shreg <= shreg_n;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Moore serial transmitter: sends a 1..WIDTH bit pattern MSB-first, optionally repeating with a gap.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LW    = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [LW-1:0]    len,
    input  logic             loop,
    input  logic             stop,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    logic [1:0]       state_n;
    logic [WIDTH-1:0] pat,    pat_n;
    logic [LW-1:0]    cnt,    cnt_n;
    logic [LW-1:0]    len_r,  len_r_n;
    logic             loop_r, loop_r_n;
    logic             stop_p, stop_p_n;
    logic             sh_load, sh_shift;
    logic [WIDTH-1:0] sh_din;
    logic             msb_next_c;
    logic [LW-1:0]    eff_c;

    assign eff_c = LW'(eff_len(32'(len), WIDTH));

    piso_shift #(.WIDTH(WIDTH)) u_piso (
        .CLK        (CLK),
        .RST        (RST),
        .load       (sh_load),
        .shift      (sh_shift),
        .din        (sh_din),
        .msb_next_c (msb_next_c)
    );

    // Next-state and register-update logic.
    always_comb begin
        state_n  = state;
        pat_n    = pat;
        cnt_n    = cnt;
        len_r_n  = len_r;
        loop_r_n = loop_r;
        stop_p_n = stop_p;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = pat;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    pat_n    = data;
                    sh_din   = data;
                    sh_load  = 1'b1;
                    len_r_n  = eff_c;
                    cnt_n    = eff_c - LW'(1);
                    loop_r_n = loop;
                    stop_p_n = 1'b0;
                    state_n  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (stop) begin
                    stop_p_n = 1'b1;
                end
                if (cnt != '0) begin
                    sh_shift = 1'b1;
                    cnt_n    = cnt - LW'(1);
                end else if (!loop_r || stop_p || stop) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    stop_p_n = 1'b1;
                end
                sh_load = 1'b1;
                cnt_n   = len_r - LW'(1);
                state_n = (stop_p || stop) ? ST_DONE : ST_SHIFT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they stay pure Moore outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_IDLE;
            pat    <= '0;
            cnt    <= '0;
            len_r  <= '0;
            loop_r <= 1'b0;
            stop_p <= 1'b0;
            x      <= 1'b0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            pat    <= pat_n;
            cnt    <= cnt_n;
            len_r  <= len_r_n;
            loop_r <= loop_r_n;
            stop_p <= stop_p_n;
            x      <= (state_n == ST_SHIFT) && msb_next_c;
            valid  <= (state_n == ST_SHIFT);
            busy   <= (state_n != ST_IDLE);
            done   <= (state_n == ST_DONE);
        end
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: expected bits queued at start, checked on every valid cycle.
module tb_serial_pattern_tx;

    logic       CLK;
    logic       RST;
    logic       start;
    logic [7:0] data;
    logic [3:0] len;
    logic       loop;
    logic       stop;
    logic       x;
    logic       valid;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        exp_q[$];

    serial_pattern_tx #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .data  (data),
        .len   (len),
        .loop  (loop),
        .stop  (stop),
        .x     (x),
        .valid (valid),
        .busy  (busy),
        .done  (done),
        .state (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Queue the MSB-first bits of one repetition, using the bench's own length rule.
    task automatic push_bits(input logic [7:0] d, input logic [3:0] l);
        int n;
        n = ((l == 0) || (l > 8)) ? 8 : int'(l);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(d[7-i]);
        end
    endtask

    // Returns in the cycle carrying the first bit.
    task automatic start_tx(input logic [7:0] d, input logic [3:0] l, input logic lp);
        data  = d;
        len   = l;
        loop  = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Scoreboard monitor on the falling edge.
    always @(negedge CLK) begin
        if (RST) begin
            if (valid) begin
                check("valid_implies_busy", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    check("x_bit", 32'(x), 32'(exp_q.pop_front()));
                end
            end else begin
                check("x_idle_zero", 32'(x), 32'd0);
            end
        end
    end

    initial begin
        RST = 1'b0; start = 1'b0; data = '0; len = '0; loop = 1'b0; stop = 1'b0;
        #2;
        check("rst_x", 32'(x), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        tick(); tick();
        RST = 1'b1;
        tick();

        // Full 8-bit pattern; start and inputs changed while busy must have no effect.
        push_bits(8'b1011_0010, 4'd8);
        start_tx(8'b1011_0010, 4'd8, 1'b0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_state_shift", 32'(state), 32'd1);
        start = 1'b1; data = 8'hFF; len = 4'd2; loop = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (i == 7) start = 1'b0;
        end
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_state_done", 32'(state), 32'd3);
        tick();
        check("t1_idle", 32'(state), 32'd0);
        check("t1_not_busy", 32'(busy), 32'd0);
        check("t1_done_low", 32'(done), 32'd0);
        loop = 1'b0;

        // Short pattern: done in the 4th cycle after capture.
        push_bits(8'b1100_0000, 4'd3);
        start_tx(8'b1100_0000, 4'd3, 1'b0);
        tick(); tick(); tick();
        check("t2_done", 32'(done), 32'd1);
        tick();
        check("t2_idle", 32'(state), 32'd0);

        // len 0 and len 9 both mean full width.
        for (int t = 0; t < 2; t++) begin
            logic [3:0] l;
            l = (t == 0) ? 4'd0 : 4'd9;
            push_bits(8'h5A, l);
            start_tx(8'h5A, l, 1'b0);
            for (int i = 0; i < 8; i++) tick();
            check("t3_done", 32'(done), 32'd1);
            tick();
            check("t3_idle", 32'(state), 32'd0);
        end

        // Loop with stop mid-pattern: third repetition completes, no gap after it.
        push_bits(8'hA5, 4'd4); push_bits(8'hA5, 4'd4); push_bits(8'hA5, 4'd4);
        start_tx(8'hA5, 4'd4, 1'b1);
        tick(); tick(); tick(); tick();
        check("t4_gap_state", 32'(state), 32'd2);
        check("t4_gap_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick(); tick();
        check("t4_stop_done", 32'(state), 32'd3);
        check("t4_stop_done_pulse", 32'(done), 32'd1);
        tick();
        check("t4_idle", 32'(state), 32'd0);

        // Loop with stop in the gap: DONE next cycle, no further bits.
        push_bits(8'hA5, 4'd4);
        start_tx(8'hA5, 4'd4, 1'b1);
        tick(); tick(); tick(); tick();
        check("t5_gap_state", 32'(state), 32'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t5_done", 32'(state), 32'd3);
        tick();
        check("t5_idle", 32'(state), 32'd0);
        loop = 1'b0;

        // Asynchronous reset during the 3rd bit, then a clean full pattern.
        push_bits(8'b1011_0010, 4'd2);
        start_tx(8'b1011_0010, 4'd8, 1'b0);
        tick(); tick();
        #2 RST = 1'b0;
        #1;
        check("t6_rst_x", 32'(x), 32'd0);
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_state", 32'(state), 32'd0);
        tick(); tick();
        RST = 1'b1;
        check("t6_sb_drained", 32'(exp_q.size()), 32'd0);
        push_bits(8'b1011_0010, 4'd8);
        start_tx(8'b1011_0010, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        check("t6_done", 32'(done), 32'd1);
        tick();

        // len 1 with start held high: period of 3 cycles.
        push_bits(8'h80, 4'd1); push_bits(8'h80, 4'd1); push_bits(8'h80, 4'd1);
        data = 8'h80; len = 4'd1; start = 1'b1;
        tick();
        check("t7_bit0_valid", 32'(valid), 32'd1);
        tick();
        check("t7_done0", 32'(state), 32'd3);
        tick();
        check("t7_idle0", 32'(state), 32'd0);
        tick();
        check("t7_bit1_valid", 32'(valid), 32'd1);
        tick(); tick(); tick();
        check("t7_bit2_valid", 32'(valid), 32'd1);
        start = 1'b0;
        tick(); tick(); tick(); tick();
        check("t7_final_idle", 32'(state), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Moore-style serial bit-stream transmitter. Loads a parallel pattern of 1..WIDTH bits and drives it MSB-first, one bit per clock, on a single serial line `x`. The line feeds the team's serial sequence-detector FSMs, which consume one bit of `x` per clock. The block optionally repeats the pattern with a one-cycle gap until asked to stop. All outputs are registered Moore outputs: they depend only on the state and internal registers, never directly on inputs.

## Interface
- `WIDTH`, default 8: maximum pattern length in bits; must be ≥ 2.
- `LW`, default $clog2(WIDTH)+1: width of the length field.
- `CLK` in 1: single clock; all state changes on the rising edge.
- `RST` in 1: reset, asynchronous and active-low.
- `start` in 1: request transmission; sampled only in IDLE.
- `data` in WIDTH: pattern; bit WIDTH-1 is sent first.
- `len` in LW: number of bits to send. 0 or any value > WIDTH means WIDTH.
- `loop` in 1: sampled with `start`; repeat the pattern until stopped.
- `stop` in 1: request end of looping; sampled in SHIFT and GAP.
- `x` out 1: serial bit; 0 whenever `valid`=0.
- `valid` out 1: `x` carries a pattern bit this cycle.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the final bit.
- `state` out 2: current state code, for debug and scoreboard.

## Operation
- Registers:
  - `pat` (WIDTH): captured pattern.
  - `shreg` (WIDTH): shift register.
  - `cnt` (LW): bits remaining minus one.
  - `len_r` (LW): effective length.
  - `loop_r`: captured `loop`.
  - `stop_p`: sticky stop request.
- States: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11.
- IDLE:
  - Outputs `x`=0, `valid`=0.
  - If `start`=1: `pat`←`data`, `shreg`←`data`, `len_r`←eff(`len`), `cnt`←eff(`len`)-1, `loop_r`←`loop`, `stop_p`←0; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Outputs `x`=`shreg[WIDTH-1]`, `valid`=1.
  - If `cnt`≠0: `shreg`←`shreg`<<1 (zero fill), `cnt`←`cnt`-1, stay in SHIFT.
  - If `cnt`=0: go to DONE when `loop_r`=0, `stop_p`=1 or `stop`=1; otherwise go to GAP.
- GAP:
  - Outputs `x`=0, `valid`=0.
  - `shreg`←`pat`, `cnt`←`len_r`-1.
  - Go to DONE if `stop_p`|`stop`; otherwise go to SHIFT.
- DONE: `done`=1, `x`=0, `valid`=0; go to IDLE unconditionally.
- `stop_p` is set by `stop`=1 in SHIFT or GAP. The current repetition always completes; stop never truncates a pattern.
- `start` outside IDLE is ignored, not queued.
- `data`, `len` and `loop` are only used at the capture edge; later changes have no effect.
- Reset, asserted at any time including mid-pattern, forces IDLE immediately:
  - all outputs 0;
  - `pat`, `shreg`, `cnt`, `len_r`, `loop_r`, `stop_p` all cleared.

## Timing
- Reset values: `x`=0, `valid`=0, `busy`=0, `done`=0, `state`=2'b00.
- `start` sampled at edge k: the first bit is on `x` in cycle k+1, with `valid` and `busy` high.
- An n-bit pattern holds `valid`=1 for exactly n consecutive cycles, k+1..k+n.
- Non-loop mode: `done`=1 in cycle k+n+1 and IDLE in cycle k+n+2. The earliest next `start` is sampled at the end of cycle k+n+2, so the minimum start-to-start period is n+2 cycles.
- Loop mode: the period is n+1 cycles (n bits plus one GAP cycle).
- `stop` sampled in GAP: DONE follows directly, with no further bits.
- `stop` coinciding with the last bit: DONE follows, with no GAP.
- n=1: SHIFT lasts one cycle.

## Structure
- Shared package `serial_tx_pkg` holds:
  - state localparams `ST_IDLE`/`ST_SHIFT`/`ST_GAP`/`ST_DONE`;
  - function `eff_len(len, WIDTH)`.
- One natural sub-module, `piso_shift`: parallel-load, MSB-first shift register with `load`/`shift` controls.
- The FSM and counter stay in the top level.

## Test plan
- WIDTH=8, `data`=8'b1011_0010, `len`=8, `loop`=0 → `x`=1,0,1,1,0,0,1,0 over 8 `valid` cycles, then `done` for 1 cycle, then IDLE; `start` stays ignored while `busy`.
- `data`=8'b1100_0000, `len`=3 → `x`=1,1,0; `done` in the 4th cycle after capture. `len`=0 and `len`=9 each send all 8 bits.
- `loop`=1, `data`=8'hA5, `len`=4 → repeating 1,0,1,0,gap,…; `stop` pulsed mid-pattern → current 4 bits complete, then DONE with no GAP. `stop` pulsed in GAP → DONE next cycle.
- `RST` low during the 3rd bit → `x`/`valid`/`busy` drop to 0 asynchronously. After release, a new `start` sends its full pattern from the MSB.
- `len`=1, `data`=8'h80, back-to-back `start` held high → `x`=1 for 1 cycle, then DONE and IDLE, then the next pattern; period 3 cycles.
- `data` and `len` changed during SHIFT → output unchanged from the captured pattern.
